// File: rtl/sc_mul_rr_sched.sv
// Round-robin front end that time-shares a single stochastic-computing multiplier
// among NUM_REQ operand sources and returns each result tagged with its owner ID.
//
// state | meaning
// IDLE  | arbitrate; grant one requester and register its operands
// EVAL  | operands held on mul_a/mul_b while the wait counter runs down
// RESP  | captured result presented on the response channel until accepted
module sc_mul_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int OP_W    = 6,
    parameter int RES_W   = 6,
    parameter int MUL_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    input  logic [NUM_REQ*OP_W-1:0] req_b,
    output logic [OP_W-1:0]         mul_a,
    output logic [OP_W-1:0]         mul_b,
    input  logic [RES_W-1:0]        mul_res,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [RES_W-1:0]        rsp_data,
    output logic                    busy,
    output logic [15:0]             op_cnt
);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    localparam logic [3:0]      LAT_M1   = 4'(MUL_LAT - 1);
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

    state_t          state, state_nx;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] win_idx;
    logic            win_found;
    logic [3:0]      wait_cnt;
    logic [OP_W-1:0] sel_a, sel_b;

    // Search starts one past the previous winner so every holder gets a turn.
    always_comb begin
        logic [ID_W:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, last} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ))
                idx = idx - (ID_W+1)'(NUM_REQ);
            if (!win_found && req_valid[idx[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                sel_a = req_a[i*OP_W +: OP_W];
                sel_b = req_b[i*OP_W +: OP_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    req_ready = NUM_REQ'(1) << win_idx;
                    state_nx  = EVAL;
                end
            end
            EVAL: begin
                if (wait_cnt == 4'd0)
                    state_nx = RESP;
            end
            RESP: begin
                if (rsp_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            op_cnt    <= '0;
            last      <= LAST_RST;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        mul_a    <= sel_a;
                        mul_b    <= sel_b;
                        rsp_id   <= win_idx;
                        last     <= win_idx;
                        wait_cnt <= LAT_M1;
                    end
                end
                EVAL: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        rsp_data  <= mul_res;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_cnt    <= op_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/sc_mul_rr_sched.md
Name: sc_mul_rr_sched

Overview:
- Round-robin scheduler that time-shares one stochastic-computing multiplier (6-bit Sobol operands in, 6-bit APC count out, combinational or fixed-latency) among NUM_REQ requesters.
- Sits between PE-level operand sources and the single shared SC multiplier instance.
- Registers the operands, waits a fixed evaluation time, captures the result, and returns it with the requester ID over a valid/ready response channel.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must satisfy 2^ID_W >= NUM_REQ.
- OP_W, 6, operand width (Sobol valid bit width) driven to the multiplier.
- RES_W, 6, multiplier result width.
- MUL_LAT, 1, cycles held in EVAL before result capture (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand-pair valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*OP_W  packed operand A; requester i uses bits [i*OP_W +: OP_W].
- req_b  in  NUM_REQ*OP_W  packed operand B; same packing as req_a.
- mul_a  out  OP_W  registered operand A to the shared multiplier.
- mul_b  out  OP_W  registered operand B to the shared multiplier.
- mul_res  in  RES_W  multiplier result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- rsp_data  out  RES_W  captured multiplier result.
- busy  out  1  high whenever state != IDLE.
- op_cnt  out  16  count of completed responses; wraps at 0xFFFF to 0.

Behaviour:
- Reset (async, rst_n=0) values:
  - State IDLE; req_ready=0; rsp_valid=0.
  - mul_a=0, mul_b=0, rsp_id=0, rsp_data=0, op_cnt=0, busy=0.
  - Round-robin pointer last=NUM_REQ-1, so the first grant goes to requester 0.
  - A reset mid-operation discards the in-flight operation; no response is produced.
- FSM states: IDLE -> EVAL -> RESP -> IDLE.
- IDLE:
  - The winner is the first i with req_valid[i]=1, searching last+1, last+2, ... modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in this cycle; every other req_ready bit is 0.
  - A handshake happens on req_valid[i] & req_ready[i].
  - On handshake, at the clock edge:
    - mul_a <= req_a slice, mul_b <= req_b slice.
    - rsp_id <= winner; last <= winner.
    - Wait counter <= MUL_LAT-1; state -> EVAL.
  - With no valid request, remain in IDLE; all registers hold.
- EVAL:
  - req_ready=0. mul_a and mul_b are held stable.
  - While the counter is non-zero, decrement it each cycle.
  - When the counter is 0, rsp_data <= mul_res, rsp_valid <= 1, state -> RESP.
  - EVAL therefore lasts exactly MUL_LAT cycles.
- RESP:
  - rsp_valid=1; rsp_id and rsp_data are held stable until the handshake.
  - On rsp_ready=1: rsp_valid <= 0, op_cnt <= op_cnt+1, state -> IDLE.
  - rsp_ready is ignored outside RESP.
- Latency: grant edge to rsp_valid rising is MUL_LAT+1 edges after the request is accepted.
- Minimum issue interval is MUL_LAT+2 cycles. Arbitration is not pipelined: a new grant happens only in IDLE, one cycle after the response handshake.
- Requester protocol:
  - Once asserted, req_valid must stay high with stable operands until that requester's req_ready.
  - A requester may drop req_valid while not granted. It then simply loses its turn, with no error.
- Fairness: a requester that holds req_valid is granted within NUM_REQ grants.
- mul_res is treated as opaque: no arithmetic and no saturation. Values 1..32 from the APC adder (count+1) pass through unchanged.
- busy = (state != IDLE), registered-state derived.

Test Plan:
- Reset/single op: reset, then req_valid=4'b0001, a=6'd20, b=6'd40, stub mul_res=6'd13, MUL_LAT=1.
  - req_ready[0]=1 in cycle 0; mul_a=20, mul_b=40 after edge 1.
  - rsp_valid=1 after edge 2 with rsp_id=0, rsp_data=13.
  - rsp_ready=1 -> op_cnt=1, busy=0.
- Round-robin: all four valid continuously, rsp_ready tied 1 -> grant order 0,1,2,3,0; one grant every 3 cycles.
- Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_id and rsp_data are stable; req_ready=0 throughout; no new grant until one cycle after rsp_ready=1.
- Pointer skip: last=1 with requesters 0 and 3 valid -> grant 3, then 0.
- MUL_LAT=4: stub changes mul_res 2 cycles after issue -> rsp_data equals the value present in the 4th EVAL cycle; rsp_valid appears 5 edges after the grant.
- Reset mid-EVAL: assert rst_n=0 during EVAL -> rsp_valid=0 immediately, op_cnt=0; after release, requester 0 is granted first even if requester 2 was in flight.
